// File: rtl/pong_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pong_game_ctrl                                             |
// | Description : Game sequencer for the Pong datapath. Tracks both scores,  |
// |               inserts serve and game-over delays counted in frame ticks, |
// |               decides the winner and drives gra_still to pong_graph.     |
// | Ports       : clk, reset (async, active-high)                            |
// |               tick      - one-clk pulse per frame                        |
// |               btn[3:0]  - debounced buttons, any rising edge starts      |
// |               hit[1:0]  - paddle-hit pulses (left, right)                |
// |               miss, miss_side - ball out of field, exit side            |
// |               gra_still, state[1:0], score_l/r[3:0], winner, serve_dir   |
// |               rally_cnt[7:0], rally_max[7:0] (RALLY_CNT_EN only)         |
// | Options     : `define RALLY_CNT_EN adds the rally hit counter outputs.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] btn,
    input  logic [1:0] hit,
    input  logic       miss,
    input  logic       miss_side,
    output logic       gra_still,
    output logic [1:0] state,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       winner,
    output logic       serve_dir
`ifdef RALLY_CNT_EN
    ,
    output logic [7:0] rally_cnt,
    output logic [7:0] rally_max
`endif
);

    localparam logic [1:0] c_ST_NEWGAME = 2'b00;
    localparam logic [1:0] c_ST_PLAY    = 2'b01;
    localparam logic [1:0] c_ST_NEWBALL = 2'b10;
    localparam logic [1:0] c_ST_OVER    = 2'b11;

    localparam logic [3:0] c_WIN_SCORE  = 4'(WIN_SCORE);
    localparam logic [7:0] c_SERVE_LOAD = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] c_OVER_LOAD  = 8'(OVER_FRAMES - 1);

    logic [1:0] r_state, w_state_nxt;
    logic [7:0] r_timer, w_timer_nxt;
    logic [3:0] r_btn_prev;
    logic [3:0] r_score_l, w_score_l_nxt;
    logic [3:0] r_score_r, w_score_r_nxt;
    logic       r_winner, w_winner_nxt;
    logic       r_serve_dir, w_serve_dir_nxt;
    logic       r_gra_still, w_gra_still_nxt;
    logic       w_start;
    logic [3:0] w_inc_l;
    logic [3:0] w_inc_r;

    assign w_start = |(btn & ~r_btn_prev);
    assign w_inc_l = r_score_l + 4'd1;
    assign w_inc_r = r_score_r + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_NEWGAME;
            r_timer     <= 8'd0;
            r_btn_prev  <= 4'd0;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_winner    <= 1'b0;
            r_serve_dir <= 1'b0;
            r_gra_still <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_btn_prev  <= btn;
            r_score_l   <= w_score_l_nxt;
            r_score_r   <= w_score_r_nxt;
            r_winner    <= w_winner_nxt;
            r_serve_dir <= w_serve_dir_nxt;
            r_gra_still <= w_gra_still_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_score_l_nxt   = r_score_l;
        w_score_r_nxt   = r_score_r;
        w_winner_nxt    = r_winner;
        w_serve_dir_nxt = r_serve_dir;
        case (r_state)
            c_ST_NEWGAME: begin
                w_score_l_nxt = 4'd0;
                w_score_r_nxt = 4'd0;
                if (w_start) w_state_nxt = c_ST_PLAY;
            end
            c_ST_PLAY: begin
                // Leaving PLAY on the first miss cycle guarantees one point
                // per miss episode; hit has no say in the sequencing.
                if (miss) begin
                    if (miss_side) begin
                        w_score_l_nxt   = w_inc_l;
                        w_serve_dir_nxt = 1'b0;
                        if (w_inc_l == c_WIN_SCORE) begin
                            w_state_nxt  = c_ST_OVER;
                            w_timer_nxt  = c_OVER_LOAD;
                            w_winner_nxt = 1'b0;
                        end else begin
                            w_state_nxt = c_ST_NEWBALL;
                            w_timer_nxt = c_SERVE_LOAD;
                        end
                    end else begin
                        w_score_r_nxt   = w_inc_r;
                        w_serve_dir_nxt = 1'b1;
                        if (w_inc_r == c_WIN_SCORE) begin
                            w_state_nxt  = c_ST_OVER;
                            w_timer_nxt  = c_OVER_LOAD;
                            w_winner_nxt = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_NEWBALL;
                            w_timer_nxt = c_SERVE_LOAD;
                        end
                    end
                end
            end
            c_ST_NEWBALL: begin
                if (tick) begin
                    if (r_timer == 8'd0) w_state_nxt = c_ST_PLAY;
                    else                 w_timer_nxt = r_timer - 8'd1;
                end
            end
            default: begin  // c_ST_OVER
                if (tick) begin
                    if (r_timer == 8'd0) begin
                        w_state_nxt   = c_ST_NEWGAME;
                        w_score_l_nxt = 4'd0;
                        w_score_r_nxt = 4'd0;
                    end else begin
                        w_timer_nxt = r_timer - 8'd1;
                    end
                end
            end
        endcase
        // Derived from the next state so it changes in the same clk as state.
        w_gra_still_nxt = (w_state_nxt != c_ST_PLAY);
    end

    assign gra_still = r_gra_still;
    assign state     = r_state;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign winner    = r_winner;
    assign serve_dir = r_serve_dir;

`ifdef RALLY_CNT_EN
    logic [7:0] r_rally_cnt, w_rally_cnt_nxt;
    logic [7:0] r_rally_max, w_rally_max_nxt;

    always_comb begin
        w_rally_cnt_nxt = r_rally_cnt;
        if (r_state == c_ST_PLAY && (|hit) && r_rally_cnt != 8'hFF)
            w_rally_cnt_nxt = r_rally_cnt + 8'd1;
        // Entering NEWBALL or NEWGAME starts a fresh rally.
        if (w_state_nxt != r_state &&
            (w_state_nxt == c_ST_NEWBALL || w_state_nxt == c_ST_NEWGAME))
            w_rally_cnt_nxt = 8'd0;
        w_rally_max_nxt = (w_rally_cnt_nxt > r_rally_max) ? w_rally_cnt_nxt : r_rally_max;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rally_cnt <= 8'd0;
            r_rally_max <= 8'd0;
        end else begin
            r_rally_cnt <= w_rally_cnt_nxt;
            r_rally_max <= w_rally_max_nxt;
        end
    end

    assign rally_cnt = r_rally_cnt;
    assign rally_max = r_rally_max;
`else
    // Without the rally counter nothing consumes the hit pulses.
    logic w_unused_hit;
    assign w_unused_hit = &{1'b0, hit};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pong_game_ctrl                                          |
// | Description : Self-checking bench for pong_game_ctrl. Expected results   |
// |               are queued when stimulus is driven and compared after the  |
// |               DUT responds. Honours `define RALLY_CNT_EN.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pong_game_ctrl;

    localparam int WIN_SCORE    = 4;
    localparam int SERVE_FRAMES = 3;
    localparam int OVER_FRAMES  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] btn;
    logic [1:0] hit;
    logic       miss;
    logic       miss_side;
    logic       gra_still;
    logic [1:0] state;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       winner;
    logic       serve_dir;
`ifdef RALLY_CNT_EN
    logic [7:0] rally_cnt;
    logic [7:0] rally_max;
`endif

    pong_game_ctrl #(
        .WIN_SCORE   (WIN_SCORE),
        .SERVE_FRAMES(SERVE_FRAMES),
        .OVER_FRAMES (OVER_FRAMES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .btn      (btn),
        .hit      (hit),
        .miss     (miss),
        .miss_side(miss_side),
        .gra_still(gra_still),
        .state    (state),
        .score_l  (score_l),
        .score_r  (score_r),
        .winner   (winner),
        .serve_dir(serve_dir)
`ifdef RALLY_CNT_EN
        ,
        .rally_cnt(rally_cnt),
        .rally_max(rally_max)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Observed outputs packed as {state, gra_still, score_l, score_r, winner, serve_dir}.
    function automatic logic [15:0] obs();
        return {3'b000, state, gra_still, score_l, score_r, winner, serve_dir};
    endfunction

    // Expected pack; gra_still follows from the expected state.
    function automatic logic [15:0] pk(logic [1:0] st, logic [3:0] sl, logic [3:0] sr,
                                       logic w, logic d);
        return {3'b000, st, (st != 2'b01), sl, sr, w, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve();
        repeat (SERVE_FRAMES) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; btn = 4'd0; hit = 2'd0; miss = 1'b0; miss_side = 1'b0;
        step(); step();
        reset = 1'b0;
        q.push_back('{name: "reset", v: pk(2'b00, 4'd0, 4'd0, 1'b0, 1'b0)});
        step();
        e = q.pop_front(); checks++;
        if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
    endtask

    task automatic test_start();
        btn = 4'b0100;
        q.push_back('{name: "start", v: pk(2'b01, 4'd0, 4'd0, 1'b0, 1'b0)});
        step();
        btn = 4'd0;
        e = q.pop_front(); checks++;
        if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
    endtask

    task automatic test_miss_episode();
        miss = 1'b1; miss_side = 1'b1;
        q.push_back('{name: "miss_once", v: pk(2'b10, 4'd1, 4'd0, 1'b0, 1'b0)});
        repeat (5) step();
        miss = 1'b0;
        e = q.pop_front(); checks++;
        if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
        for (int t = 1; t <= SERVE_FRAMES; t++) begin
            tick = 1'b1;
            q.push_back('{name: $sformatf("serve_tick%0d", t),
                          v: pk((t < SERVE_FRAMES) ? 2'b10 : 2'b01, 4'd1, 4'd0, 1'b0, 1'b0)});
            step();
            tick = 1'b0;
            e = q.pop_front(); checks++;
            if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
        end
    endtask

    task automatic test_miss_with_hit();
        miss = 1'b1; miss_side = 1'b1; hit = 2'b10;
        q.push_back('{name: "miss_hit", v: pk(2'b10, 4'd2, 4'd0, 1'b0, 1'b0)});
        step();
        miss = 1'b0; hit = 2'b00;
        e = q.pop_front(); checks++;
        if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
        serve();
    endtask

    task automatic test_win_right();
        for (int i = 1; i <= WIN_SCORE; i++) begin
            miss = 1'b1; miss_side = 1'b0;
            q.push_back('{name: $sformatf("right_point%0d", i),
                          v: pk((i < WIN_SCORE) ? 2'b10 : 2'b11, 4'd2, 4'(i),
                                (i == WIN_SCORE), 1'b1)});
            step();
            miss = 1'b0;
            e = q.pop_front(); checks++;
            if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
            if (i < WIN_SCORE) serve();
        end
        btn = 4'b1000;
        q.push_back('{name: "over_btn", v: pk(2'b11, 4'd2, 4'd4, 1'b1, 1'b1)});
        step(); btn = 4'd0; step();
        e = q.pop_front(); checks++;
        if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
        for (int t = 1; t <= OVER_FRAMES; t++) begin
            tick = 1'b1;
            q.push_back('{name: $sformatf("over_tick%0d", t),
                          v: (t < OVER_FRAMES) ? pk(2'b11, 4'd2, 4'd4, 1'b1, 1'b1)
                                               : pk(2'b00, 4'd0, 4'd0, 1'b1, 1'b1)});
            step();
            tick = 1'b0;
            e = q.pop_front(); checks++;
            if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
        end
    endtask

    task automatic test_newgame_idle();
        q.push_back('{name: "newgame_ticks", v: pk(2'b00, 4'd0, 4'd0, 1'b1, 1'b1)});
        repeat (3) begin tick = 1'b1; step(); tick = 1'b0; step(); end
        e = q.pop_front(); checks++;
        if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
        btn = 4'b0001;
        q.push_back('{name: "restart", v: pk(2'b01, 4'd0, 4'd0, 1'b1, 1'b1)});
        step(); btn = 4'd0;
        e = q.pop_front(); checks++;
        if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
        hit = 2'b01;
        q.push_back('{name: "hit_ignored", v: pk(2'b01, 4'd0, 4'd0, 1'b1, 1'b1)});
        step(); hit = 2'b00; step();
        e = q.pop_front(); checks++;
        if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 3; i++) begin
            miss = 1'b1; miss_side = 1'b1; step(); miss = 1'b0;
            if (i < 3) serve();
        end
        q.push_back('{name: "left_three", v: pk(2'b10, 4'd3, 4'd0, 1'b1, 1'b0)});
        e = q.pop_front(); checks++;
        if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
        // Assert reset mid-cycle and look before the next rising edge.
        #1 reset = 1'b1;
        q.push_back('{name: "async_reset", v: pk(2'b00, 4'd0, 4'd0, 1'b0, 1'b0)});
        #1;
        e = q.pop_front(); checks++;
        if (obs() !== e.v) begin $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); errors++; end
        step();
        reset = 1'b0;
        step();
    endtask

`ifdef RALLY_CNT_EN
    task automatic test_rally();
        btn = 4'b0100; step(); btn = 4'd0;
        repeat (4) begin hit = 2'b01; step(); hit = 2'b00; step(); end
        q.push_back('{name: "rally_four", v: {8'd4, 8'd4}});
        e = q.pop_front(); checks++;
        if ({rally_cnt, rally_max} !== e.v) begin
            $display("FAIL %s: got %h expected %h", e.name, {rally_cnt, rally_max}, e.v); errors++;
        end
        miss = 1'b1; miss_side = 1'b1;
        q.push_back('{name: "rally_cleared", v: {8'd0, 8'd4}});
        step(); miss = 1'b0;
        e = q.pop_front(); checks++;
        if ({rally_cnt, rally_max} !== e.v) begin
            $display("FAIL %s: got %h expected %h", e.name, {rally_cnt, rally_max}, e.v); errors++;
        end
        serve();
        hit = 2'b11;
        q.push_back('{name: "rally_saturate", v: {8'd255, 8'd255}});
        repeat (300) step();
        hit = 2'b00;
        e = q.pop_front(); checks++;
        if ({rally_cnt, rally_max} !== e.v) begin
            $display("FAIL %s: got %h expected %h", e.name, {rally_cnt, rally_max}, e.v); errors++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_miss_episode();
        test_miss_with_hit();
        test_win_right();
        test_newgame_idle();
        test_async_reset();
`ifdef RALLY_CNT_EN
        test_rally();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
